pci_rr_bus_arbiter: RTL and testbench



---
 rtl/pci_rr_bus_arbiter.sv | 131 +++++++++++++
 tb/tb_pci_rr_bus_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pci_rr_bus_arbiter.sv
// Central round-robin PCI bus arbiter.
// Drives one active-low GNT# per initiator, watches FRAME#/IRDY# to learn
// when the bus is idle, reclaims grants that are never used, and pre-empts
// the current owner as soon as another initiator is waiting.
module pci_rr_bus_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_n,
    input  logic            frame_n,
    input  logic            irdy_n,
    output logic [NREQ-1:0] gnt_n,
    output logic [IDW-1:0]  owner,
    output logic            bus_busy
);

    typedef enum logic [1:0] {
        IDLE,
        GRANTED,
        BUSY,
        DRAIN
    } stateT;

    localparam logic [NREQ-1:0] OneHot0     = NREQ'(1);
    localparam logic [7:0]      TimeoutLast = 8'(TIMEOUT - 1);

    stateT           state;
    logic [IDW-1:0]  last;
    logic [7:0]      grantCnt;
    logic [IDW-1:0]  winner;
    logic [IDW-1:0]  scanIdx;
    logic            anyReq;
    logic [NREQ-1:0] ownerMask;
    logic            otherReq;
    logic            busIdle;

    assign busIdle   = frame_n & irdy_n;
    assign ownerMask = OneHot0 << owner;
    assign otherReq  = |(~req_n & ~ownerMask);

    // Round-robin pick: scan downwards so the nearest requester after 'last' is written last and wins.
    always_comb begin
        winner  = '0;
        anyReq  = 1'b0;
        scanIdx = '0;
        for (int i = NREQ; i >= 1; i--) begin
            scanIdx = IDW'((int'(last) + i) % NREQ);
            if (!req_n[scanIdx]) begin
                winner = scanIdx;
                anyReq = 1'b1;
            end
        end
    end

    // Arbitration FSM with registered grants, owner, priority pointer, grant timer and busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt_n    <= '1;
            owner    <= '0;
            last     <= IDW'(NREQ - 1);
            grantCnt <= '0;
            bus_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        gnt_n    <= ~(OneHot0 << winner);
                        owner    <= winner;
                        grantCnt <= '0;
                        state    <= GRANTED;
                    end else begin
                        gnt_n <= '1;
                    end
                end

                GRANTED: begin
                    if (grantCnt != 8'hFF) begin
                        grantCnt <= grantCnt + 8'd1;
                    end
                    if (!frame_n) begin
                        last     <= owner;
                        bus_busy <= 1'b1;
                        state    <= BUSY;
                    end else if (req_n[owner]) begin
                        gnt_n <= '1;
                        state <= IDLE;
                    end else if (grantCnt == TimeoutLast) begin
                        gnt_n <= '1;
                        last  <= owner;
                        state <= IDLE;
                    end
                end

                BUSY: begin
                    if (otherReq) begin
                        gnt_n <= '1;
                        state <= DRAIN;
                    end else if (busIdle) begin
                        bus_busy <= 1'b0;
                        if (!req_n[owner]) begin
                            grantCnt <= '0;
                            state    <= GRANTED;
                        end else begin
                            gnt_n <= '1;
                            state <= IDLE;
                        end
                    end
                end

                DRAIN: begin
                    gnt_n <= '1;
                    if (busIdle) begin
                        bus_busy <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: begin
                    gnt_n    <= '1;
                    bus_busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pci_rr_bus_arbiter.sv
// Directed bench for the round-robin PCI arbiter: reset values, first grant,
// rotation with pre-emption, grant timeout, withdrawn request, DRAIN gap and
// asynchronous reset in the middle of a transaction.
module tb_pci_rr_bus_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req_n;
    logic       frame_n;
    logic       irdy_n;
    logic [3:0] gnt_n;
    logic [1:0] owner;
    logic       bus_busy;

    int checks = 0;
    int errors = 0;

    pci_rr_bus_arbiter #(
        .NREQ   (4),
        .IDW    (2),
        .TIMEOUT(16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req_n   (req_n),
        .frame_n (frame_n),
        .irdy_n  (irdy_n),
        .gnt_n   (gnt_n),
        .owner   (owner),
        .bus_busy(bus_busy)
    );

    // Free-running bus clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [3:0] req, input logic frame, input logic irdy);
        req_n   = req;
        frame_n = frame;
        irdy_n  = irdy;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] expGnt,
                               input logic [1:0] expOwner, input logic expBusy);
        checks++;
        assert (gnt_n === expGnt && owner === expOwner && bus_busy === expBusy)
        else begin
            errors++;
            $error("[TB] FAIL %s: got gnt_n=%b owner=%0d bus_busy=%b, expected gnt_n=%b owner=%0d bus_busy=%b",
                   tag, gnt_n, owner, bus_busy, expGnt, expOwner, expBusy);
        end
    endtask

    initial begin
        int order [5] = '{0, 1, 2, 3, 0};
        logic [3:0] expGnt;
        logic [1:0] expIdx;

        rst = 1'b1;
        applyStimulus(4'b1111, 1'b1, 1'b1);
        tick(2);
        checkOutput("reset", 4'b1111, 2'd0, 1'b0);
        rst = 1'b0;

        // First grant and a single transaction with back-to-back regrant.
        applyStimulus(4'b1110, 1'b1, 1'b1);
        tick(1);
        checkOutput("firstGrant", 4'b1110, 2'd0, 1'b0);
        applyStimulus(4'b1110, 1'b0, 1'b0);
        tick(1);
        checkOutput("frameToBusy", 4'b1110, 2'd0, 1'b1);
        tick(1);
        checkOutput("busyHold", 4'b1110, 2'd0, 1'b1);
        applyStimulus(4'b1110, 1'b1, 1'b0);
        tick(1);
        checkOutput("lastDataPhase", 4'b1110, 2'd0, 1'b1);
        applyStimulus(4'b1110, 1'b1, 1'b1);
        tick(1);
        checkOutput("backToBack", 4'b1110, 2'd0, 1'b0);
        applyStimulus(4'b1111, 1'b1, 1'b1);
        tick(1);
        checkOutput("withdrawIdle", 4'b1111, 2'd0, 1'b0);

        // Fresh reset so rotation starts at index 0.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        applyStimulus(4'b0000, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            expIdx = 2'(order[k]);
            expGnt = ~(4'b0001 << expIdx);
            tick(1);
            checkOutput($sformatf("rrGrant%0d", k), expGnt, expIdx, 1'b0);
            applyStimulus(4'b0000, 1'b0, 1'b0);
            tick(1);
            checkOutput($sformatf("rrBusy%0d", k), expGnt, expIdx, 1'b1);
            tick(1);
            checkOutput($sformatf("rrPreempt%0d", k), 4'b1111, expIdx, 1'b1);
            tick(1);
            checkOutput($sformatf("rrDrain%0d", k), 4'b1111, expIdx, 1'b1);
            applyStimulus(4'b0000, 1'b1, 1'b0);
            tick(1);
            checkOutput($sformatf("rrDrainIrdy%0d", k), 4'b1111, expIdx, 1'b1);
            applyStimulus(4'b0000, 1'b1, 1'b1);
            tick(1);
            checkOutput($sformatf("rrIdle%0d", k), 4'b1111, expIdx, 1'b0);
        end
        applyStimulus(4'b1111, 1'b1, 1'b1);

        // Unused grant to master 1 must be withdrawn after exactly 16 clocks.
        applyStimulus(4'b1101, 1'b1, 1'b1);
        tick(1);
        checkOutput("toGrant", 4'b1101, 2'd1, 1'b0);
        for (int c = 1; c < 16; c++) begin
            tick(1);
            checkOutput($sformatf("toHold%0d", c), 4'b1101, 2'd1, 1'b0);
        end
        tick(1);
        checkOutput("toExpire", 4'b1111, 2'd1, 1'b0);
        applyStimulus(4'b1001, 1'b1, 1'b1);
        tick(1);
        checkOutput("toNextIs2", 4'b1011, 2'd2, 1'b0);

        // Master 2 withdraws before FRAME#; priority pointer must stay at 1.
        applyStimulus(4'b1111, 1'b1, 1'b1);
        tick(1);
        checkOutput("withdraw2", 4'b1111, 2'd2, 1'b0);
        applyStimulus(4'b1010, 1'b1, 1'b1);
        tick(1);
        checkOutput("regrant2", 4'b1011, 2'd2, 1'b0);
        applyStimulus(4'b1111, 1'b1, 1'b1);
        tick(1);
        checkOutput("withdraw2Again", 4'b1111, 2'd2, 1'b0);

        // Master 0 owns the bus, master 3 requests: pre-empt and wait for idle.
        applyStimulus(4'b1110, 1'b1, 1'b1);
        tick(1);
        checkOutput("peGrant0", 4'b1110, 2'd0, 1'b0);
        applyStimulus(4'b1110, 1'b0, 1'b0);
        tick(1);
        checkOutput("peBusy0", 4'b1110, 2'd0, 1'b1);
        tick(1);
        checkOutput("peHold0", 4'b1110, 2'd0, 1'b1);
        applyStimulus(4'b0110, 1'b0, 1'b0);
        tick(1);
        checkOutput("pePreempt", 4'b1111, 2'd0, 1'b1);
        tick(1);
        checkOutput("peDrainFrame", 4'b1111, 2'd0, 1'b1);
        applyStimulus(4'b0110, 1'b1, 1'b0);
        tick(1);
        checkOutput("peDrainIrdy", 4'b1111, 2'd0, 1'b1);
        applyStimulus(4'b0110, 1'b1, 1'b1);
        tick(1);
        checkOutput("peIdleGap", 4'b1111, 2'd0, 1'b0);
        tick(1);
        checkOutput("peGrant3", 4'b0111, 2'd3, 1'b0);

        // Asynchronous reset while master 3 is mid-transaction.
        applyStimulus(4'b0110, 1'b0, 1'b0);
        tick(1);
        checkOutput("arBusy3", 4'b0111, 2'd3, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arAsync", 4'b1111, 2'd0, 1'b0);
        tick(1);
        checkOutput("arHeld", 4'b1111, 2'd0, 1'b0);
        rst = 1'b0;
        applyStimulus(4'b0000, 1'b1, 1'b1);
        tick(1);
        checkOutput("arFirstGrant", 4'b1110, 2'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
